// File: rtl/drop_release_timer_if.sv
// Handshake/status bundle between the drop controller and the release timer.
interface drop_release_timer_if;
    logic        start;
    logic [15:0] t_in;
    logic        drop_en;
    logic        abort;
    logic        busy;
    logic [15:0] t_remaining;
    logic        drop_activated;
    logic        done;

    modport master (
        output start, t_in, drop_en, abort,
        input  busy, t_remaining, drop_activated, done
    );

    modport slave (
        input  start, t_in, drop_en, abort,
        output busy, t_remaining, drop_activated, done
    );
endinterface

// File: rtl/drop_release_timer.sv
// Counts the 8.8 fall time down in prescaled ticks, then pulses the drop
// release for HOLD_CYCLES cycles while the drop is enabled.
module drop_release_timer #(
    parameter int PRESCALE    = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    drop_release_timer_if.slave  io
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_WAIT_EN = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        // Abort is checked first everywhere so it always wins over start or expiry.
        if (io.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.start && !io.abort) begin
                        state_d = S_COUNT;
                        cnt_d   = io.t_in;
                        pre_d   = '0;
                        hold_d  = '0;
                    end
                end
                S_COUNT: begin
                    if (cnt_q == 16'd0) begin
                        pre_d   = '0;
                        hold_d  = '0;
                        state_d = io.drop_en ? S_DROP : S_WAIT_EN;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_WAIT_EN: begin
                    if (io.drop_en) begin
                        state_d = S_DROP;
                        hold_d  = '0;
                    end
                end
                S_DROP: begin
                    // drop_en is deliberately ignored here: a started release always completes.
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign io.busy           = (state_q != S_IDLE);
    assign io.drop_activated = (state_q == S_DROP);
    assign io.t_remaining    = cnt_q;
    assign io.done           = done_q;
endmodule

// File: tb/tb_drop_release_timer.sv
// Directed bench for drop_release_timer with PRESCALE=4, HOLD_CYCLES=3.
module tb_drop_release_timer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    drop_release_timer_if io ();

    drop_release_timer #(.PRESCALE(4), .HOLD_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge 0 (the edge that samples start).
    task automatic start_pulse(input logic [15:0] v);
        io.t_in  = v;
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io.start   = $urandom_range(0, 1);
            io.abort   = $urandom_range(0, 1);
            io.drop_en = $urandom_range(0, 1);
            io.t_in    = 16'($urandom);
            tick();
            total++;
            if ({io.busy, io.t_remaining, io.drop_activated, io.done} !== 19'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got busy=%b trem=%h drop=%b done=%b want all 0",
                         i, io.busy, io.t_remaining, io.drop_activated, io.done);
            end
        end
        io.start = 1'b0; io.abort = 1'b0; io.drop_en = 1'b0; io.t_in = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_long_count();
        logic [15:0] v = 16'h0BCA;
        logic [15:0] exp_t;
        io.drop_en = 1'b1;
        start_pulse(v);
        for (int k = 1; k <= 12072; k++) begin
            tick();
            exp_t = v - 16'(k / 4);
            total++;
            if (io.busy !== 1'b1 || io.t_remaining !== exp_t || io.drop_activated !== 1'b0) begin
                bad++;
                $display("FAIL long_count edge=%0d got busy=%b trem=%h drop=%b want busy=1 trem=%h drop=0",
                         k, io.busy, io.t_remaining, io.drop_activated, exp_t);
            end
        end
        for (int k = 12073; k <= 12075; k++) begin
            tick();
            total++;
            if (io.drop_activated !== 1'b1 || io.done !== 1'b0 || io.busy !== 1'b1) begin
                bad++;
                $display("FAIL long_drop edge=%0d got drop=%b done=%b busy=%b want drop=1 done=0 busy=1",
                         k, io.drop_activated, io.done, io.busy);
            end
        end
        tick();
        total++;
        if (io.done !== 1'b1 || io.drop_activated !== 1'b0 || io.busy !== 1'b0) begin
            bad++;
            $display("FAIL long_done edge=12076 got done=%b drop=%b busy=%b want done=1 drop=0 busy=0",
                     io.done, io.drop_activated, io.busy);
        end
        tick();
        total++;
        if (io.done !== 1'b0) begin
            bad++;
            $display("FAIL long_done_width edge=12077 got done=%b want 0", io.done);
        end
    endtask

    task automatic test_zero_time();
        io.drop_en = 1'b1;
        start_pulse(16'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (io.drop_activated !== 1'b1 || io.busy !== 1'b1 || io.t_remaining !== 16'd0) begin
                bad++;
                $display("FAIL zero_drop edge=%0d got drop=%b busy=%b trem=%h want drop=1 busy=1 trem=0",
                         k, io.drop_activated, io.busy, io.t_remaining);
            end
        end
        tick();
        total++;
        if (io.done !== 1'b1 || io.drop_activated !== 1'b0) begin
            bad++;
            $display("FAIL zero_done edge=4 got done=%b drop=%b want done=1 drop=0", io.done, io.drop_activated);
        end
        tick();
    endtask

    task automatic test_wait_enable();
        io.drop_en = 1'b0;
        start_pulse(16'd2);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 4) begin
                total++;
                if (io.t_remaining !== 16'd1) begin
                    bad++;
                    $display("FAIL wait_mid edge=4 got trem=%h want 0001", io.t_remaining);
                end
            end
            if (k >= 8) begin
                total++;
                if (io.t_remaining !== 16'd0 || io.busy !== 1'b1 || io.drop_activated !== 1'b0) begin
                    bad++;
                    $display("FAIL wait_hold edge=%0d got trem=%h busy=%b drop=%b want trem=0 busy=1 drop=0",
                             k, io.t_remaining, io.busy, io.drop_activated);
                end
            end
        end
        io.drop_en = 1'b1;
        for (int k = 20; k <= 22; k++) begin
            tick();
            total++;
            if (io.drop_activated !== 1'b1) begin
                bad++;
                $display("FAIL wait_drop edge=%0d got drop=%b want 1", k, io.drop_activated);
            end
        end
        tick();
        total++;
        if (io.done !== 1'b1 || io.drop_activated !== 1'b0 || io.busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_done edge=23 got done=%b drop=%b busy=%b want 1 0 0",
                     io.done, io.drop_activated, io.busy);
        end
        tick();
    endtask

    task automatic test_abort_and_restart();
        io.drop_en = 1'b1;
        start_pulse(16'd100);
        for (int k = 1; k <= 9; k++) tick();
        io.start = 1'b1;
        io.t_in  = 16'd5;
        tick();
        io.start = 1'b0;
        total++;
        if (io.t_remaining !== 16'd98 || io.busy !== 1'b1) begin
            bad++;
            $display("FAIL ignored_start edge=10 got trem=%0d busy=%b want 98 1", io.t_remaining, io.busy);
        end
        for (int k = 11; k <= 49; k++) tick();
        total++;
        if (io.t_remaining !== 16'd88) begin
            bad++;
            $display("FAIL abort_pre edge=49 got trem=%0d want 88", io.t_remaining);
        end
        io.abort = 1'b1;
        tick();
        io.abort = 1'b0;
        total++;
        if (io.busy !== 1'b0 || io.t_remaining !== 16'd0 || io.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle edge=50 got busy=%b trem=%h done=%b want 0 0 0",
                     io.busy, io.t_remaining, io.done);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (io.done !== 1'b0 || io.busy !== 1'b0 || io.drop_activated !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b drop=%b want 0 0 0",
                         k, io.done, io.busy, io.drop_activated);
            end
        end
        io.start = 1'b1; io.abort = 1'b1; io.t_in = 16'd7;
        tick();
        io.start = 1'b0; io.abort = 1'b0;
        total++;
        if (io.busy !== 1'b0 || io.t_remaining !== 16'd0) begin
            bad++;
            $display("FAIL abort_start_same got busy=%b trem=%h want 0 0", io.busy, io.t_remaining);
        end
    endtask

    task automatic test_reset_mid_drop();
        io.drop_en = 1'b1;
        start_pulse(16'd0);
        tick();
        total++;
        if (io.drop_activated !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got drop=%b want 1", io.drop_activated);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (io.drop_activated !== 1'b0 || io.busy !== 1'b0 || io.done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async got drop=%b busy=%b done=%b want 0 0 0",
                     io.drop_activated, io.busy, io.done);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (io.busy !== 1'b0 || io.drop_activated !== 1'b0 || io.done !== 1'b0 || io.t_remaining !== 16'd0) begin
                bad++;
                $display("FAIL midrst_idle cyc=%0d got busy=%b drop=%b done=%b trem=%h want all 0",
                         k, io.busy, io.drop_activated, io.done, io.t_remaining);
            end
        end
        start_pulse(16'd1);
        tick();
        total++;
        if (io.busy !== 1'b1 || io.t_remaining !== 16'd1) begin
            bad++;
            $display("FAIL midrst_restart got busy=%b trem=%h want 1 0001", io.busy, io.t_remaining);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        io.start = 1'b0; io.abort = 1'b0; io.drop_en = 1'b0; io.t_in = '0;
        test_reset();
        test_long_count();
        test_zero_time();
        test_wait_enable();
        test_abort_and_restart();
        test_reset_mid_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/drop_release_timer.md
Name: drop_release_timer

Overview:
- Sits directly downstream of the square-root stage in the baggage-drop datapath.
- Takes the 16-bit fall-time result (8.8 unsigned fixed point) from the square-root stage and counts it down in scaled clock ticks.
- At expiry, and only while the drop is enabled, it drives the drop-release output for a fixed hold time.
- Reports busy, remaining time and a completion pulse to the controlling FSM.

Parameters:
- PRESCALE, 4: clock cycles per 1 LSB (1/256 unit) of t_in. Minimum 1.
- HOLD_CYCLES, 3: cycles drop_activated stays high. Minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; samples t_in. Ignored unless the block is IDLE.
- t_in  input  16  fall time from the square-root stage, unsigned 8.8.
- drop_en  input  1  level; release is permitted while high.
- abort  input  1  synchronous cancel; takes priority over start.
- busy  output  1  high in any state other than IDLE.
- t_remaining  output  16  current countdown value, same 8.8 format.
- drop_activated  output  1  release strobe, registered.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE
  - cnt, prescaler and hold counters = 0
  - busy = 0, t_remaining = 0, drop_activated = 0, done = 0
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- States:
  - IDLE:
    - start=1 and abort=0: cnt <= t_in, pre <= 0, go to COUNT.
    - Otherwise hold.
  - COUNT:
    - If cnt==0: go to DROP when drop_en=1, else WAIT_EN.
    - Else pre increments each cycle. When pre==PRESCALE-1: pre <= 0 and cnt <= cnt-1.
  - WAIT_EN:
    - cnt stays 0.
    - Go to DROP on the first edge where drop_en=1.
  - DROP:
    - drop_activated=1 while in this state; hold counter runs HOLD_CYCLES cycles.
    - On the last cycle: go to IDLE, drop_activated <= 0, done <= 1 for exactly one cycle.
- Timing: start sampled at edge 0, t_in=V, drop_en=1 throughout.
  - cnt reaches 0 at edge V*PRESCALE.
  - drop_activated rises after edge V*PRESCALE+1 and stays high HOLD_CYCLES cycles.
  - done is high in the cycle immediately after drop_activated falls.
- Arithmetic:
  - cnt is 16 bits and never decrements below 0.
  - Prescaler is clog2(PRESCALE) bits wide, minimum 1.
  - No overflow is possible. The maximum countdown is 65535*PRESCALE cycles.
- Boundaries:
  - t_in=0: drop decision at edge 1 (drop or wait).
  - start while busy: ignored, t_in not resampled.
  - abort in COUNT, WAIT_EN or DROP: IDLE at the next edge, drop_activated <= 0, done stays 0, t_remaining <= 0.
  - abort and start in the same IDLE cycle: remain IDLE.
  - drop_en falling during DROP: no effect; the hold completes.
  - rst_n low mid-operation: all outputs 0 immediately, without waiting for a clock.
- t_remaining = cnt in all states; 0 in IDLE after completion or abort.

Test Plan (PRESCALE=4, HOLD_CYCLES=3):
1. Hold rst_n low, toggle clk and all inputs -> busy=0, t_remaining=0, drop_activated=0, done=0 throughout.
2. t_in=16'h0BCA (sqrt(139) ≈ 11.79), start pulse, drop_en=1:
   - busy=1 from edge 1.
   - t_remaining decrements every 4 cycles; equals 0 at edge 12072.
   - drop_activated high during cycles after edges 12073-12075.
   - done single pulse after edge 12076, then busy=0.
3. t_in=0, start, drop_en=1 -> drop_activated high after edge 1 for 3 cycles; done after edge 4.
4. t_in=2, drop_en=0:
   - t_remaining reaches 0 at edge 8; busy=1, drop_activated=0 (WAIT_EN).
   - Raise drop_en at edge 20 -> drop_activated high after edge 20 for 3 cycles, then done.
5. Abort and ignored start:
   - t_in=100, start, abort at edge 50 -> busy=0 and t_remaining=0 after edge 50, done never asserts.
   - Separately, a second start with t_in=5 at edge 10 of a running count -> ignored, countdown unchanged.
6. During DROP (drop_activated=1), pull rst_n low between clock edges -> drop_activated, busy and done go 0 immediately. After release the block sits in IDLE until a new start.
